// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment display peripheral: register offsets,
// segment glyphs and the double-dabble adjust step.
package seg7_pkg;

    localparam logic [1:0] SEG_LO   = 2'b00;
    localparam logic [1:0] SEG_HI   = 2'b01;
    localparam logic [1:0] SEG_MODE = 2'b10;

    // Active-low {dp,g,f,e,d,c,b,a}
    localparam logic [7:0] HEX_GLYPH [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };
    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef enum logic [1:0] {
        BCD_IDLE  = 2'b00,
        BCD_SHIFT = 2'b01,
        BCD_DONE  = 2'b10
    } bcd_state_t;

    function automatic logic [7:0] hex_glyph(input logic [3:0] nib);
        return HEX_GLYPH[nib];
    endfunction

    function automatic logic [39:0] dabble_adjust(input logic [39:0] acc);
        logic [39:0] res;
        res = acc;
        for (int i = 0; i < 10; i++) begin
            if (res[4*i +: 4] >= 4'd5) begin
                res[4*i +: 4] = res[4*i +: 4] + 4'd3;
            end else begin
                res[4*i +: 4] = res[4*i +: 4];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/seg7_display_if.sv
// IO-write bus from the CPU address decode into the display peripheral.
interface seg7_display_if;
    logic        SegCtrl;
    logic        ioWrite;
    logic [1:0]  segAddr;
    logic [15:0] write_data;

    modport master (output SegCtrl, output ioWrite, output segAddr, output write_data);
    modport slave  (input  SegCtrl, input  ioWrite, input  segAddr, input  write_data);
endinterface

// File: rtl/seg7_bin2bcd.sv
// Restartable sequential double-dabble: 32 shift cycles plus one DONE cycle.
module seg7_bin2bcd
    import seg7_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [31:0] i_val,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_bcd,
    output logic        o_ovf
);

    bcd_state_t  r_state, w_state_next;
    logic [39:0] r_acc, w_acc_next, w_adj;
    logic [31:0] r_sh, w_sh_next;
    logic [4:0]  r_cnt, w_cnt_next;
    logic [71:0] w_shifted;

    assign w_adj     = dabble_adjust(r_acc);
    assign w_shifted = {w_adj, r_sh} << 1;

    // State and datapath registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= BCD_IDLE;
            r_acc   <= 40'd0;
            r_sh    <= 32'd0;
            r_cnt   <= 5'd0;
        end else begin
            r_state <= w_state_next;
            r_acc   <= w_acc_next;
            r_sh    <= w_sh_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state logic; a start in any state reloads from the new value
    always_comb begin
        w_state_next = r_state;
        w_acc_next   = r_acc;
        w_sh_next    = r_sh;
        w_cnt_next   = r_cnt;
        if (i_start) begin
            w_state_next = BCD_SHIFT;
            w_acc_next   = 40'd0;
            w_sh_next    = i_val;
            w_cnt_next   = 5'd0;
        end else begin
            case (r_state)
                BCD_IDLE: w_state_next = BCD_IDLE;
                BCD_SHIFT: begin
                    w_acc_next = w_shifted[71:32];
                    w_sh_next  = w_shifted[31:0];
                    w_cnt_next = r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        w_state_next = BCD_DONE;
                    end else begin
                        w_state_next = BCD_SHIFT;
                    end
                end
                BCD_DONE: w_state_next = BCD_IDLE;
                default:  w_state_next = BCD_IDLE;
            endcase
        end
    end

    assign o_busy = (r_state != BCD_IDLE);
    assign o_done = (r_state == BCD_DONE) && !i_start;
    assign o_bcd  = r_acc[31:0];
    // Any digit above the eighth means the value reached 100,000,000
    assign o_ovf  = |r_acc[39:32];

endmodule

// File: rtl/seg7_display.sv
// Memory-mapped 8-digit common-anode display: register file, optional BCD
// conversion, and a glitch-free registered digit scan.
module seg7_display
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV = 23000,
    parameter int DIGITS   = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    seg7_display_if.slave        bus,
    output logic [7:0]           seg_en,
    output logic [7:0]           seg_out,
    output logic                 busy
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = $clog2(DIGITS);

    logic [31:0]      r_val, w_val_next;
    logic             r_mode, w_mode_next;
    logic [7:0]       r_mask, w_mask_next;
    logic [31:0]      r_bcd;
    logic             r_ovf;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic [IDX_W-1:0] r_idx, w_idx_next;
    logic [7:0]       r_seg_en, r_seg_out, w_en_next, w_glyph;
    logic [3:0]       w_val_nib, w_bcd_nib;
    logic             w_wr_ok, w_start, w_wrap;
    logic             w_bcd_busy, w_bcd_done, w_bcd_ovf;
    logic [31:0]      w_bcd_res;

    // Register write decode; the post-write mode decides whether to convert
    always_comb begin
        w_val_next  = r_val;
        w_mode_next = r_mode;
        w_mask_next = r_mask;
        w_wr_ok     = 1'b0;
        if (bus.SegCtrl && bus.ioWrite) begin
            case (bus.segAddr)
                SEG_LO: begin
                    w_val_next[15:0] = bus.write_data;
                    w_wr_ok          = 1'b1;
                end
                SEG_HI: begin
                    w_val_next[31:16] = bus.write_data;
                    w_wr_ok           = 1'b1;
                end
                SEG_MODE: begin
                    w_mode_next = bus.write_data[0];
                    w_mask_next = bus.write_data[15:8];
                    w_wr_ok     = 1'b1;
                end
                default: w_wr_ok = 1'b0;
            endcase
        end else begin
            w_wr_ok = 1'b0;
        end
        w_start = w_wr_ok && w_mode_next;
    end

    seg7_bin2bcd u_bin2bcd (
        .i_clk   (clock),
        .i_reset (reset),
        .i_start (w_start),
        .i_val   (w_val_next),
        .o_busy  (w_bcd_busy),
        .o_done  (w_bcd_done),
        .o_bcd   (w_bcd_res),
        .o_ovf   (w_bcd_ovf)
    );

    // Scan counter and glyph for the digit that becomes active on this edge
    always_comb begin
        w_wrap = (r_cnt == CNT_W'(SCAN_DIV - 1));
        if (w_wrap) begin
            w_cnt_next = {CNT_W{1'b0}};
            w_idx_next = r_idx + IDX_W'(1);
        end else begin
            w_cnt_next = r_cnt + CNT_W'(1);
            w_idx_next = r_idx;
        end
        w_val_nib = r_val[{w_idx_next, 2'b00} +: 4];
        w_bcd_nib = r_bcd[{w_idx_next, 2'b00} +: 4];
        if (!r_mode) begin
            w_glyph = hex_glyph(w_val_nib);
        end else if (r_ovf) begin
            w_glyph = SEG_DASH;
        end else begin
            w_glyph = hex_glyph(w_bcd_nib);
        end
        w_en_next             = 8'hFF;
        w_en_next[w_idx_next] = ~r_mask[w_idx_next];
    end

    // Registers, displayed BCD result and registered display outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            r_val     <= 32'd0;
            r_mode    <= 1'b0;
            r_mask    <= 8'hFF;
            r_bcd     <= 32'd0;
            r_ovf     <= 1'b0;
            r_cnt     <= {CNT_W{1'b0}};
            r_idx     <= {IDX_W{1'b0}};
            r_seg_en  <= 8'hFF;
            r_seg_out <= SEG_BLANK;
        end else begin
            r_val     <= w_val_next;
            r_mode    <= w_mode_next;
            r_mask    <= w_mask_next;
            r_cnt     <= w_cnt_next;
            r_idx     <= w_idx_next;
            r_seg_en  <= w_en_next;
            r_seg_out <= w_glyph;
            if (w_bcd_done) begin
                r_bcd <= w_bcd_res;
                r_ovf <= w_bcd_ovf;
            end
        end
    end

    assign seg_en  = r_seg_en;
    assign seg_out = r_seg_out;
    assign busy    = w_bcd_busy;

endmodule

// File: tb/tb_seg7_display.sv
// Directed self-checking bench for seg7_display with a 4-cycle digit slot.
module tb_seg7_display;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] seg_en, seg_out;
    logic       busy;
    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] seen [8];
    bit         seen_ok;

    seg7_display_if bus();

    seg7_display #(.SCAN_DIV(4), .DIGITS(8)) dut (
        .clock   (clock),
        .reset   (reset),
        .bus     (bus),
        .seg_en  (seg_en),
        .seg_out (seg_out),
        .busy    (busy)
    );

    always #5 clock = ~clock;

    task automatic do_write(input logic [1:0] addr, input logic [15:0] data,
                            input logic sel, input logic we);
        @(negedge clock);
        bus.SegCtrl    = sel;
        bus.ioWrite    = we;
        bus.segAddr    = addr;
        bus.write_data = data;
        @(negedge clock);
        bus.SegCtrl = 1'b0;
        bus.ioWrite = 1'b0;
    endtask

    task automatic wait_digit(input int d, output bit found);
        logic [7:0] want;
        want  = ~(8'h01 << d);
        found = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clock);
            if (seg_en == want) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic scan_glyphs();
        bit f;
        seen_ok = 1'b1;
        for (int d = 0; d < 8; d++) begin
            wait_digit(d, f);
            if (!f) seen_ok = 1'b0;
            seen[d] = seg_out;
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [7:0] want;
        bus.SegCtrl = 1'b0; bus.ioWrite = 1'b0; bus.segAddr = 2'b00; bus.write_data = 16'h0000;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        n_checks++; if (seg_en !== 8'hFF) $display("FAIL reset_seg_en got=%h exp=ff", seg_en); else n_pass++;
        n_checks++; if (seg_out !== 8'hFF) $display("FAIL reset_seg_out got=%h exp=ff", seg_out); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
        reset = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clock);
            want = ~(8'h01 << (k / 4));
            n_checks++;
            if (seg_en !== want) $display("FAIL scan_step%0d got=%h exp=%h", k, seg_en, want);
            else n_pass++;
            if (k == 1) begin
                n_checks++;
                if (seg_out !== 8'hC0) $display("FAIL reset_glyph got=%h exp=c0", seg_out);
                else n_pass++;
            end
        end
    endtask

    task automatic test_hex();
        logic [7:0] exp_g [8];
        logic [7:0] prev;
        int         n;
        bit         synced;
        exp_g = '{8'h8E, 8'h86, 8'h86, 8'h83, 8'hA1, 8'h88, 8'h86, 8'hA1};
        do_write(2'b00, 16'hBEEF, 1'b1, 1'b1);
        do_write(2'b01, 16'hDEAD, 1'b1, 1'b1);
        n_checks++; if (busy !== 1'b0) $display("FAIL hex_no_busy got=%b exp=0", busy); else n_pass++;
        repeat (2) @(negedge clock);
        scan_glyphs();
        for (int d = 0; d < 8; d++) begin
            n_checks++;
            if (!seen_ok || seen[d] !== exp_g[d])
                $display("FAIL hex_digit%0d got=%h exp=%h found=%b", d, seen[d], exp_g[d], seen_ok);
            else n_pass++;
        end
        // Measure between two consecutive first cycles of digit 1
        synced = 1'b0;
        prev   = seg_en;
        for (int i = 0; i < 64; i++) begin
            @(negedge clock);
            if (seg_en == 8'hFD && prev != 8'hFD) begin synced = 1'b1; break; end
            prev = seg_en;
        end
        n = 0;
        prev = seg_en;
        for (int i = 0; i < 64 && synced; i++) begin
            @(negedge clock);
            n++;
            if (seg_en == 8'hFD && prev != 8'hFD) break;
            prev = seg_en;
        end
        n_checks++;
        if (!synced || n != 32) $display("FAIL scan_period got=%0d exp=32", n); else n_pass++;
    endtask

    task automatic test_bcd();
        logic [7:0] exp_g [8];
        bit         ok;
        int         n;
        exp_g = '{8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0, 8'hC0, 8'hC0};
        do_write(2'b01, 16'h0000, 1'b1, 1'b1);
        do_write(2'b00, 16'h0000, 1'b1, 1'b1);
        do_write(2'b10, 16'hFF01, 1'b1, 1'b1);
        wait_idle(ok);
        n_checks++; if (!ok) $display("FAIL bcd_mode_idle got=busy exp=idle"); else n_pass++;
        do_write(2'b00, 16'd12345, 1'b1, 1'b1);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            if (!busy) break;
            n++;
            @(negedge clock);
        end
        n_checks++; if (n != 33) $display("FAIL bcd_busy_len got=%0d exp=33", n); else n_pass++;
        repeat (2) @(negedge clock);
        scan_glyphs();
        for (int d = 0; d < 8; d++) begin
            n_checks++;
            if (!seen_ok || seen[d] !== exp_g[d])
                $display("FAIL bcd_digit%0d got=%h exp=%h found=%b", d, seen[d], exp_g[d], seen_ok);
            else n_pass++;
        end
    endtask

    task automatic test_ovf();
        bit ok;
        do_write(2'b01, 16'h05F5, 1'b1, 1'b1);
        do_write(2'b00, 16'hE0FF, 1'b1, 1'b1);
        wait_idle(ok);
        n_checks++; if (!ok) $display("FAIL max_idle got=busy exp=idle"); else n_pass++;
        repeat (2) @(negedge clock);
        scan_glyphs();
        for (int d = 0; d < 8; d++) begin
            n_checks++;
            if (!seen_ok || seen[d] !== 8'h90) $display("FAIL nines_digit%0d got=%h exp=90", d, seen[d]);
            else n_pass++;
        end
        do_write(2'b00, 16'hE100, 1'b1, 1'b1);
        wait_idle(ok);
        n_checks++; if (!ok) $display("FAIL ovf_idle got=busy exp=idle"); else n_pass++;
        repeat (2) @(negedge clock);
        scan_glyphs();
        for (int d = 0; d < 8; d++) begin
            n_checks++;
            if (!seen_ok || seen[d] !== 8'hBF) $display("FAIL dash_digit%0d got=%h exp=bf", d, seen[d]);
            else n_pass++;
        end
    endtask

    task automatic test_restart();
        logic [7:0] old_g [8];
        logic [7:0] new_g [8];
        logic [7:0] want;
        bit         ok;
        int         n, bad;
        old_g = '{8'hC0, 8'hC0, 8'h82, 8'hF8, 8'h92, 8'hC0, 8'hC0, 8'hC0};
        new_g = '{8'hA4, 8'h99, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
        do_write(2'b01, 16'h0000, 1'b1, 1'b1);
        wait_idle(ok);
        repeat (2) @(negedge clock);
        scan_glyphs();
        n_checks++;
        if (!ok || !seen_ok || seen[2] !== old_g[2] || seen[3] !== old_g[3] || seen[4] !== old_g[4])
            $display("FAIL restart_pre got=%h%h%h exp=%h%h%h", seen[4], seen[3], seen[2], old_g[4], old_g[3], old_g[2]);
        else n_pass++;
        do_write(2'b00, 16'd1, 1'b1, 1'b1);
        n = 0; bad = 0;
        for (int i = 0; i < 200; i++) begin
            if (!busy) break;
            n++;
            if (n == 10) begin
                bus.SegCtrl = 1'b1; bus.ioWrite = 1'b1; bus.segAddr = 2'b00; bus.write_data = 16'd42;
            end
            if (n == 11) begin
                bus.SegCtrl = 1'b0; bus.ioWrite = 1'b0;
            end
            for (int d = 0; d < 8; d++) begin
                want = ~(8'h01 << d);
                if (seg_en == want && seg_out !== old_g[d]) bad++;
            end
            @(negedge clock);
        end
        n_checks++; if (n != 43) $display("FAIL restart_busy_len got=%0d exp=43", n); else n_pass++;
        n_checks++; if (bad != 0) $display("FAIL restart_hold_old got=%0d bad exp=0", bad); else n_pass++;
        repeat (2) @(negedge clock);
        scan_glyphs();
        for (int d = 0; d < 8; d++) begin
            n_checks++;
            if (!seen_ok || seen[d] !== new_g[d]) $display("FAIL restart_digit%0d got=%h exp=%h", d, seen[d], new_g[d]);
            else n_pass++;
        end
    endtask

    task automatic test_mask_ignore();
        logic [7:0] exp_g [4];
        bit         f;
        int         n_dark, n_hi;
        exp_g = '{8'h88, 8'hA4, 8'hC0, 8'hC0};
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 0) begin
                do_write(2'b10, 16'h0F00, 1'b1, 1'b1);
                n_checks++; if (busy !== 1'b0) $display("FAIL mask_no_busy got=%b exp=0", busy); else n_pass++;
            end else begin
                do_write(2'b11, 16'hFFFF, 1'b1, 1'b1);
                do_write(2'b00, 16'h1234, 1'b0, 1'b1);
                do_write(2'b01, 16'h1234, 1'b1, 1'b0);
                do_write(2'b10, 16'hFF01, 1'b0, 1'b1);
                n_checks++; if (busy !== 1'b0) $display("FAIL ignore_no_busy got=%b exp=0", busy); else n_pass++;
            end
            repeat (2) @(negedge clock);
            n_dark = 0; n_hi = 0;
            for (int i = 0; i < 32; i++) begin
                @(negedge clock);
                if (seg_en == 8'hFF) n_dark++;
                if (seg_en[7:4] !== 4'hF) n_hi++;
            end
            n_checks++;
            if (n_dark != 16 || n_hi != 0) $display("FAIL mask_slots%0d got=%0d/%0d exp=16/0", pass, n_dark, n_hi);
            else n_pass++;
            for (int d = 0; d < 4; d++) begin
                wait_digit(d, f);
                n_checks++;
                if (!f || seg_out !== exp_g[d]) $display("FAIL mask_digit%0d_%0d got=%h exp=%h", pass, d, seg_out, exp_g[d]);
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_hex();
        test_bcd();
        test_ovf();
        test_restart();
        test_mask_ignore();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seg7_display.md
Name: seg7_display

Overview:
- Memory-mapped seven-segment display peripheral, directly downstream of the CPU's MemOrIO address decode; a sibling of the led block.
- Captures 16-bit IO writes into a 32-bit display value and a mode register.
- Optionally converts the value to BCD with a sequential double-dabble engine.
- Time-multiplexes 8 common-anode digits on the board display.

Parameters:
- SCAN_DIV, 23000: clock cycles per digit slot (1 kHz per digit at the 23 MHz cpuclk).
- DIGITS, 8: number of digits scanned; fixed at 8, present for documentation only.

Ports:
- clock  input  1  CPU clock (cpuclk output)
- reset  input  1  synchronous, active-high
- SegCtrl  input  1  address-decode select for the display region, from MemOrIO
- ioWrite  input  1  IO write strobe from control32
- segAddr  input  2  register offset, from memoryAddress[1:0]
- write_data  input  16  write data, from writeData[15:0]
- seg_en  output  8  digit enables, active-low, bit i = digit i (digit 0 rightmost)
- seg_out  output  8  segments, active-low, {dp,g,f,e,d,c,b,a}
- busy  output  1  BCD conversion in progress

Behaviour:
- Reset values:
  - Registers: val=0, mode=0 (hex), mask=8'hFF, bcd=0, scan counter=0, digit index=0, busy=0.
  - Outputs: seg_en=8'hFF, seg_out=8'hFF.
  - Reset mid-conversion aborts the conversion; there is no partial update.
- Register write: occurs when SegCtrl & ioWrite, on the rising edge. Decoding by segAddr:
  - 00: val[15:0] <= write_data.
  - 01: val[31:16] <= write_data.
  - 10: mode <= write_data[0]; mask <= write_data[15:8].
  - 11: ignored.
- Conversion trigger:
  - Any accepted write to offsets 00, 01 or 10 while mode (post-write) = 1 starts a conversion on the next cycle.
  - A trigger while busy restarts the conversion from the new val. The displayed bcd is unchanged until completion.
- BCD engine (FSM IDLE -> SHIFT -> DONE -> IDLE):
  - SHIFT runs 32 iterations, one per cycle: add-3 on each nibble >=5, then shift in val MSB-first.
  - DONE latches the low 8 BCD nibbles into bcd and sets ovf = (val >= 100_000_000).
  - busy=1 from the first SHIFT cycle through DONE inclusive, i.e. 33 cycles. bcd updates on the edge ending DONE.
- Glyph selection for digit i:
  - Hex mode: nibble val[4i+3:4i], glyphs 0-9, A, b, C, d, E, F.
  - Decimal mode, ovf=0: bcd nibble i.
  - Decimal mode, ovf=1: dash (segment g only).
  - dp is always off.
- Scan:
  - Counter counts 0..SCAN_DIV-1 and wraps. On wrap, the digit index increments modulo 8.
  - seg_en = ~(1<<index) & ~mask... precisely: seg_en[i] = !(index==i && mask[i]).
  - Masked digits stay dark but still consume their slot.
  - seg_en and seg_out are registered together so there is no glitch between digits. Both outputs change on the same edge as the index update.
- Simultaneous events: a register write and a scan wrap on the same edge both take effect. The new glyph appears in the next registered output.

Decomposition:
- Shared package seg7_pkg:
  - Register offset constants SEG_LO=2'b00, SEG_HI=2'b01, SEG_MODE=2'b10.
  - The 16-entry hex-to-segment constant table, plus SEG_DASH and SEG_BLANK.
- One sub-module, seg7_bin2bcd: start/val in, busy/done/bcd[31:0]/ovf out, restartable. It contains the double-dabble FSM.
- Scan, register file and glyph mux stay in seg7_display.

Test Plan (SCAN_DIV=4):
- Reset held 2 cycles -> seg_en=8'hFF, seg_out=8'hFF, busy=0. After release, digit 0 is enabled within 1 cycle and advances every 4 cycles.
- Write 00<-16'hBEEF, 01<-16'hDEAD, hex mode -> digit 0 shows F (seg_out=8'h8E) and digit 7 shows d (8'hA1); one full scan is 32 cycles.
- Write 10<-16'hFF01, then 00<-16'd12345 -> busy high for exactly 33 cycles. Digits 0-4 show 5,4,3,2,1 and digits 5-7 show 0.
- Decimal mode, write 01<-16'h05F5, 00<-16'hE100 (100,000,000) -> after completion every digit shows dash 8'hBF.
- Start a conversion, then write 00 again at busy cycle 10 -> busy is extended (33 cycles from the restart). The old bcd is displayed throughout, then only the final value appears.
- Write 10<-16'h0F00 -> digits 4-7 keep seg_en bit high during their slots. segAddr=11 writes and writes with SegCtrl=0 change nothing.
